// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU requester (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, ALUop, a, b,
        input  result, zero, overflow, hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, ALUop, a, b,
        output result, zero, overflow, hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative shift-add multiply
// and restoring divide, one bit per cycle, into hi/lo.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_ADDU  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_SUBU  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_MULT  = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic             neg_q, neg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic             overflow_q, overflow_d, done_q, done_d, dbz_q, dbz_d;

    // Signed mult/div ops all have ALUop[0] set; iterations run on magnitudes.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, sum, diff;

    assign a_neg = bus.ALUop[0] & bus.a[WIDTH-1];
    assign b_neg = bus.ALUop[0] & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;
    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;

    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_next, mul_fin;

    assign mul_add  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_add, acc_lo_q[WIDTH-1:1]};
    assign mul_fin  = neg_q ? -mul_next : mul_next;

    // The partial remainder stays below the divisor, so bit WIDTH of the trial is its sign.
    logic [WIDTH:0]   div_shift, div_trial;
    logic             div_qbit;
    logic [WIDTH-1:0] div_rem, div_quo;

    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_qbit  = ~div_trial[WIDTH];
    assign div_rem   = div_qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo   = {acc_lo_q[WIDTH-2:0], div_qbit};

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ALUop)
            OP_ADDU: alu_res = sum;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:   alu_res = bus.a | bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_SUBU: alu_res = diff;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        result_d   = result_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        overflow_d = overflow_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.ALUop)
                        OP_MULTU, OP_MULT: begin
                            state_d  = MUL;
                            count_d  = '0;
                            acc_hi_d = '0;
                            acc_lo_d = b_mag;
                            opnd_d   = a_mag;
                            neg_d    = a_neg ^ b_neg;
                        end
                        OP_DIVU, OP_DIV: begin
                            if (bus.b == '0) begin
                                lo_d   = '1;
                                hi_d   = bus.a;
                                dbz_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                state_d  = DIV;
                                count_d  = '0;
                                acc_hi_d = '0;
                                acc_lo_d = a_mag;
                                opnd_d   = b_mag;
                                neg_d    = a_neg ^ b_neg;
                                rneg_d   = a_neg;
                                dbz_d    = 1'b0;
                            end
                        end
                        default: begin
                            result_d   = alu_res;
                            overflow_d = alu_ovf;
                            done_d     = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                {acc_hi_d, acc_lo_d} = mul_next;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d      = IDLE;
                    {hi_d, lo_d} = mul_fin;
                    done_d       = 1'b1;
                end
            end
            DIV: begin
                acc_hi_d = div_rem;
                acc_lo_d = div_quo;
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = IDLE;
                    lo_d    = neg_q ? -div_quo : div_quo;
                    hi_d    = rneg_q ? -div_rem : div_rem;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            result_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            result_q   <= result_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.zero        = (result_q == '0);
    assign bus.overflow    = overflow_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal >= 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port start  input  1  operation request, sampled in IDLE only.
REQ-005 SHALL have port ALUop  input  4  operation select.
REQ-006 SHALL have ports a, b  input  WIDTH  operands.
REQ-007 SHALL have port result  output  WIDTH  registered result.
REQ-008 SHALL have port zero  output  1  result == 0.
REQ-009 SHALL have port overflow  output  1  signed overflow of last add/sub.
REQ-010 SHALL have ports hi, lo  output  WIDTH  multiply/divide result registers.
REQ-011 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port div_by_zero  output  1  last divide had b == 0.

Function
REQ-014 SHALL decode ALUop: 0000 addu, 0001 add, 0010 or, 0011 and, 0100 subu, 0101 sub, 0110 sltu (unsigned), 0111 slt (signed), 1000 xor, 1001 nor, 1010 multu, 1011 mult, 1100 divu, 1101 div; others -> result 0, single-cycle.
REQ-015 SHALL latch a, b, ALUop when start=1 in IDLE; later operand changes have no effect.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV; IDLE->MUL on start with mult/multu, IDLE->DIV on start with div/divu and b != 0, MUL/DIV->IDLE after WIDTH iteration cycles.
REQ-017 Single-cycle ops: result (and overflow) registered at edge sampling start; done=1 for the following cycle; busy stays 0.
REQ-018 Mult/div: busy=1 from the cycle after start through the last iteration cycle; hi/lo written and done=1 exactly WIDTH+1 cycles after the start edge; result unchanged.
REQ-019 Multiply SHALL be shift-add, one bit per cycle; {hi,lo} = full 2*WIDTH-bit product; mult on magnitudes then negated if operand signs differ.
REQ-020 Divide SHALL be restoring, one bit per cycle; lo = quotient, hi = remainder; div: quotient truncates toward zero, remainder takes dividend sign.
REQ-021 div with a = most-negative, b = -1 SHALL give lo = most-negative (wrap), hi = 0, no flag.
REQ-022 Divide with b == 0 SHALL complete as single-cycle: lo = all ones, hi = a, div_by_zero=1, done next cycle, busy 0; any other divide clears div_by_zero.
REQ-023 overflow SHALL be set only by add/sub on signed overflow (operand signs agree with each other for add / differ for sub, and result sign differs from a); every other single-cycle op clears it; result still written.
REQ-024 start while busy SHALL be ignored (no queuing); start in the done cycle SHALL be accepted.
REQ-025 zero SHALL be combinational from the registered result only.
REQ-026 done SHALL be exactly one cycle wide per accepted operation.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, result=0, hi=0, lo=0, overflow=0, busy=0, done=0, div_by_zero=0 (zero=1), including mid-operation; no done for an aborted operation.
REQ-028 After rst deasserts, first start SHALL be accepted on the next rising edge.

Verification (WIDTH=32)
REQ-029 add a=0x7FFFFFFF b=1 -> result 0x80000000, overflow 1, done 1 cycle later; addu same -> overflow 0.
REQ-030 slt a=0xFFFFFFFF b=1 -> result 1; sltu same -> result 0, zero 1.
REQ-031 mult a=0xFFFFFFFE(-2) b=3 -> hi 0xFFFFFFFF, lo 0xFFFFFFFA, busy 32 cycles, done at start+33; start pulses during busy ignored.
REQ-032 div a=0xFFFFFFF9(-7) b=2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; div a=0x80000000 b=0xFFFFFFFF -> lo 0x80000000, hi 0.
REQ-033 divu a=5 b=0 -> lo 0xFFFFFFFF, hi 5, div_by_zero 1, busy never 1.
REQ-034 rst asserted 10 cycles into multu -> busy 0, hi/lo 0 same cycle, no done; new start afterwards completes normally.
